// File: rtl/alu_sequencer.sv
// alu_sequencer: registered initiator for the combinational ALU.
// Accepts one operation from decode, drives the ALU from registers, captures
// the ALU result and flags one cycle later and holds the bundle until the
// consumer takes it. Deliberately non-pipelined: IDLE -> EXEC -> HOLD.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             opValid,
  output logic             opReady,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [1:0]       cond,
  output logic [5:0]       ctrlALU,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] result,
  input  logic             of,
  input  logic             je,
  input  logic             ja,
  output logic             resValid,
  input  logic             resReady,
  output logic [WIDTH-1:0] resData,
  output logic             resOf,
  output logic             resEq,
  output logic             resAbove,
  output logic             takeBranch,
  output logic             illegal,
  output logic             ofSticky,
  input  logic             clrOf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [5:0] OP_MAX = 6'h09;

  localparam logic [1:0] COND_NONE  = 2'b00;
  localparam logic [1:0] COND_EQ    = 2'b01;
  localparam logic [1:0] COND_ABOVE = 2'b10;
  localparam logic [1:0] COND_ALWAYS = 2'b11;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic             w_take;
  logic             w_illegal_op;

  logic             r_op_ready;
  logic [5:0]       r_ctrl;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic [1:0]       r_cond;
  logic             r_illegal_op;

  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_of;
  logic             r_res_eq;
  logic             r_res_above;
  logic             r_take;
  logic             r_illegal;
  logic             r_of_sticky;

  assign w_illegal_op = (opcode > OP_MAX) ? 1'b1 : 1'b0;

  // Next-state and handshake strobes of the IDLE/EXEC/HOLD controller.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (opValid && r_op_ready) begin
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: begin
        w_capture    = 1'b1;
        w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (resReady) begin
          w_release    = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_HOLD;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Branch decision from the latched condition and the live ALU flags.
  always_comb begin
    w_take = 1'b0;
    case (r_cond)
      COND_NONE:   w_take = 1'b0;
      COND_EQ:     w_take = je;
      COND_ABOVE:  w_take = ja;
      COND_ALWAYS: w_take = 1'b1;
      default:     w_take = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // opReady is registered so it stays low while reset is held and only
  // rises once the controller is really able to accept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_op_ready <= 1'b0;
    end else begin
      r_op_ready <= (w_next_state == S_IDLE) ? 1'b1 : 1'b0;
    end
  end

  // Issue registers: ALU control/operands plus the condition and illegal
  // bit, loaded on accept and otherwise held at the last issued values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ctrl       <= 6'h00;
      r_in1        <= '0;
      r_in2        <= '0;
      r_cond       <= 2'b00;
      r_illegal_op <= 1'b0;
    end else if (w_accept) begin
      r_ctrl       <= opcode;
      r_in1        <= opA;
      r_in2        <= opB;
      r_cond       <= cond;
      r_illegal_op <= w_illegal_op;
    end else begin
      r_ctrl       <= r_ctrl;
      r_in1        <= r_in1;
      r_in2        <= r_in2;
      r_cond       <= r_cond;
      r_illegal_op <= r_illegal_op;
    end
  end

  // Result bundle: captured at the end of EXEC, held through HOLD.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_res_data  <= '0;
      r_res_of    <= 1'b0;
      r_res_eq    <= 1'b0;
      r_res_above <= 1'b0;
      r_take      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_capture) begin
      r_res_data  <= result;
      r_res_of    <= of;
      r_res_eq    <= je;
      r_res_above <= ja;
      r_take      <= w_take;
      r_illegal   <= r_illegal_op;
    end else begin
      r_res_data  <= r_res_data;
      r_res_of    <= r_res_of;
      r_res_eq    <= r_res_eq;
      r_res_above <= r_res_above;
      r_take      <= r_take;
      r_illegal   <= r_illegal;
    end
  end

  // resValid rises with the capture and drops when the consumer accepts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_res_valid <= 1'b0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
    end else if (w_release) begin
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= r_res_valid;
    end
  end

  // Sticky overflow; an overflow captured in the same cycle as clrOf wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_of_sticky <= 1'b0;
    end else if (clrOf) begin
      r_of_sticky <= w_capture & of;
    end else if (w_capture) begin
      r_of_sticky <= r_of_sticky | of;
    end else begin
      r_of_sticky <= r_of_sticky;
    end
  end

  assign opReady    = r_op_ready;
  assign ctrlALU    = r_ctrl;
  assign in1        = r_in1;
  assign in2        = r_in2;
  assign resValid   = r_res_valid;
  assign resData    = r_res_data;
  assign resOf      = r_res_of;
  assign resEq      = r_res_eq;
  assign resAbove   = r_res_above;
  assign takeBranch = r_take;
  assign illegal    = r_illegal;
  assign ofSticky   = r_of_sticky;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          opValid;
  logic          opReady;
  logic [5:0]    opcode;
  logic [W-1:0]  opA, opB;
  logic [1:0]    cond;
  logic [5:0]    ctrlALU;
  logic [W-1:0]  in1, in2;
  logic [W-1:0]  alu_res;
  logic          alu_of, alu_je, alu_ja;
  logic          resValid, resReady;
  logic [W-1:0]  resData;
  logic          resOf, resEq, resAbove, takeBranch, illegal, ofSticky, clrOf;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  cnd;
    logic [31:0] data;
    logic        ovf;
    logic        eq;
    logic        above;
    logic        take;
    logic        ill;
  } vec_t;

  vec_t vecs[17];
  vec_t sb_q[$];
  logic exp_sticky;

  always #5 clock = ~clock;

  alu_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .opValid(opValid), .opReady(opReady),
    .opcode(opcode), .opA(opA), .opB(opB), .cond(cond),
    .ctrlALU(ctrlALU), .in1(in1), .in2(in2),
    .result(alu_res), .of(alu_of), .je(alu_je), .ja(alu_ja),
    .resValid(resValid), .resReady(resReady),
    .resData(resData), .resOf(resOf), .resEq(resEq), .resAbove(resAbove),
    .takeBranch(takeBranch), .illegal(illegal),
    .ofSticky(ofSticky), .clrOf(clrOf)
  );

  // Behavioural ALU: signed overflow for add/sub, full-width shift amounts.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (ctrlALU)
      6'h00: alu_res = in1;
      6'h01: begin
        alu_res = in1 + in2;
        alu_of  = (in1[31] == in2[31]) && (alu_res[31] != in1[31]);
      end
      6'h02: begin
        alu_res = in1 - in2;
        alu_of  = (in1[31] != in2[31]) && (alu_res[31] != in1[31]);
      end
      6'h03: alu_res = in1 * in2;
      6'h04: alu_res = in1 & in2;
      6'h05: alu_res = in1 | in2;
      6'h06: alu_res = in1 ^ in2;
      6'h07: alu_res = ~in1;
      6'h08: alu_res = in1 << in2;
      6'h09: alu_res = in1 >> in2;
      default: alu_res = '0;
    endcase
  end
  assign alu_je = (in1 == in2);
  assign alu_ja = ($signed(in1) > $signed(in2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Wait for opReady, present one operation for a single accept, push expectation.
  task automatic issue(input vec_t v);
    int n;
    n = 0;
    while (!opReady && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("op_ready_wait", {31'd0, opReady}, 32'd1);
    opValid = 1'b1;
    opcode  = v.op;
    opA     = v.a;
    opB     = v.b;
    cond    = v.cnd;
    sb_q.push_back(v);
    @(negedge clock);
    opValid = 1'b0;
  endtask

  // Wait for the bundle, compare against the scoreboard, optionally stall, then drain.
  task automatic collect(input int start, input int hold, input string tag);
    int   cycles;
    vec_t e;
    cycles = start;
    while (!resValid && cycles < 8) begin
      @(negedge clock);
      cycles++;
    end
    check({tag, "_latency"}, cycles, 32'd2);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      exp_sticky = exp_sticky | e.ovf;
      check({tag, "_data"},  resData, e.data);
      check({tag, "_of"},    {31'd0, resOf}, {31'd0, e.ovf});
      check({tag, "_eq"},    {31'd0, resEq}, {31'd0, e.eq});
      check({tag, "_above"}, {31'd0, resAbove}, {31'd0, e.above});
      check({tag, "_take"},  {31'd0, takeBranch}, {31'd0, e.take});
      check({tag, "_ill"},   {31'd0, illegal}, {31'd0, e.ill});
      check({tag, "_sticky"}, {31'd0, ofSticky}, {31'd0, exp_sticky});
      check({tag, "_ready_hold"}, {31'd0, opReady}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        opValid = 1'b1;
        opcode  = 6'h05;
        opA     = 32'h1234_5678;
        opB     = 32'h0000_0001;
        @(negedge clock);
        check({tag, "_bp_valid"}, {31'd0, resValid}, 32'd1);
        check({tag, "_bp_data"},  resData, e.data);
        check({tag, "_bp_ready"}, {31'd0, opReady}, 32'd0);
        check({tag, "_bp_ctrl"},  {26'd0, ctrlALU}, {26'd0, e.op});
        check({tag, "_bp_in1"},   in1, e.a);
      end
      opValid = 1'b0;
    end
    resReady = 1'b1;
    @(negedge clock);
    resReady = 1'b0;
    check({tag, "_drained"}, {31'd0, resValid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          op     a             b             cnd   data          of    eq    ab    tk    ill
    vecs[0]  = '{6'h01, 32'd7,        32'd5,        2'd0, 32'd12,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{6'h01, 32'h7FFFFFFF, 32'd1,        2'd0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{6'h02, 32'd5,        32'd5,        2'd1, 32'd0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{6'h02, 32'd5,        32'd6,        2'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'h02, 32'd1,        32'hFFFFFFFF, 2'd2, 32'd2,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{6'h02, 32'hFFFFFFFF, 32'd1,        2'd2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'h2A, 32'd3,        32'd4,        2'd3, 32'd0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{6'h03, 32'h00010000, 32'h00010000, 2'd0, 32'd0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'h08, 32'd1,        32'd33,       2'd0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'h09, 32'h80000000, 32'd4,        2'd0, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{6'h07, 32'h0F0F0F0F, 32'd0,        2'd3, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{6'h04, 32'h0000F0F0, 32'h0000FF00, 2'd0, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{6'h05, 32'h0000F0F0, 32'h0000FF00, 2'd0, 32'h0000FFF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{6'h06, 32'h0000F0F0, 32'h0000FF00, 2'd0, 32'h00000FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{6'h00, 32'hDEADBEEF, 32'd0,        2'd1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{6'h03, 32'd6,        32'd7,        2'd0, 32'd42,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{6'h02, 32'h80000000, 32'd1,        2'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b0; opValid = 1'b0; opcode = 6'h00; opA = '0; opB = '0; cond = 2'b00;
    resReady = 1'b0; clrOf = 1'b0; exp_sticky = 1'b0;

    // Reset state while reset is held.
    repeat (3) @(negedge clock);
    check("rst_ready",  {31'd0, opReady}, 32'd0);
    check("rst_valid",  {31'd0, resValid}, 32'd0);
    check("rst_ctrl",   {26'd0, ctrlALU}, 32'd0);
    check("rst_in1",    in1, 32'd0);
    check("rst_in2",    in2, 32'd0);
    check("rst_data",   resData, 32'd0);
    check("rst_sticky", {31'd0, ofSticky}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rel_ready", {31'd0, opReady}, 32'd1);

    // Table of operations; the first one also exercises backpressure.
    for (int i = 0; i < 17; i++) begin
      issue(vecs[i]);
      collect(1, (i == 0) ? 3 : 0, $sformatf("vec%0d", i));
    end

    // clrOf pulse clears the sticky bit.
    clrOf = 1'b1;
    @(negedge clock);
    clrOf = 1'b0;
    exp_sticky = 1'b0;
    check("clr_sticky", {31'd0, ofSticky}, 32'd0);

    // clrOf coincident with an overflow capture: capture wins.
    issue(vecs[1]);
    clrOf = 1'b1;
    @(negedge clock);
    clrOf = 1'b0;
    collect(2, 0, "clr_vs_capture");

    // Reset while the next operation is in EXEC discards it.
    v = '{6'h01, 32'd2, 32'd3, 2'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    issue(v);
    void'(sb_q.pop_front());
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid",  {31'd0, resValid}, 32'd0);
    check("mid_rst_ctrl",   {26'd0, ctrlALU}, 32'd0);
    check("mid_rst_in1",    in1, 32'd0);
    check("mid_rst_in2",    in2, 32'd0);
    check("mid_rst_sticky", {31'd0, ofSticky}, 32'd0);
    check("mid_rst_ready",  {31'd0, opReady}, 32'd0);
    reset = 1'b1;
    exp_sticky = 1'b0;
    @(negedge clock);
    check("mid_rel_ready", {31'd0, opReady}, 32'd1);
    @(negedge clock);
    check("mid_rel_valid", {31'd0, resValid}, 32'd0);

    // Normal operation resumes after reset.
    issue(vecs[15]);
    collect(1, 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
